// File: rtl/fp_pkg.sv
// Shared floating-point definitions: flag bit positions, operand classes,
// special-result encodings and width-generic packing helpers.
package fp_pkg;

  // Bit positions inside the 4-bit flags word {invalid, overflow, underflow, inexact}
  localparam int FLAG_INX = 0;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_INV = 3;
  localparam int FLAG_W   = 4;

  // Widest word the pack helpers can build; callers truncate to their own width
  localparam int PACK_W = 64;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_e;

  // Result override decided from the operand classes in the first stage
  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_QNAN = 2'd1,
    SP_INF  = 2'd2,
    SP_ZERO = 2'd3
  } fp_special_e;

  // Exponent zero covers true zeros and denormals (denormals flush to zero)
  function automatic fp_class_e classify(input logic exp_ones, input logic exp_zero,
                                         input logic frac_zero);
    if (exp_zero) begin
      classify = ZERO;
    end else if (exp_ones) begin
      classify = frac_zero ? INF : NAN;
    end else begin
      classify = NORM;
    end
  endfunction

  function automatic logic [PACK_W-1:0] pack_zero(input int exp_w, input int man_w,
                                                  input logic sign);
    pack_zero = {{(PACK_W-1){1'b0}}, sign} << (exp_w + man_w);
  endfunction

  function automatic logic [PACK_W-1:0] pack_inf(input int exp_w, input int man_w,
                                                 input logic sign);
    pack_inf = pack_zero(exp_w, man_w, sign) |
               (((64'd1 << exp_w) - 64'd1) << man_w);
  endfunction

  // Canonical quiet NaN: positive, all-ones exponent, only the top fraction bit set
  function automatic logic [PACK_W-1:0] pack_qnan(input int exp_w, input int man_w);
    pack_qnan = (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised fraction with guard and sticky bits.
// A carry out means the fraction wrapped to zero and the exponent must grow by one.
module fp_round_rne #(
  parameter int MAN_W = 23
) (
  input  logic [MAN_W-1:0] man_in,
  input  logic             guard,
  input  logic             sticky,
  output logic [MAN_W-1:0] man_out,
  output logic             carry,
  output logic             inexact
);

  logic             round_up_s;
  logic [MAN_W:0]   sum_s;

  // Increment when above half an ulp, or exactly half with an odd lsb
  always_comb begin
    round_up_s = guard & (sticky | man_in[0]);
    sum_s      = {1'b0, man_in} + {{MAN_W{1'b0}}, round_up_s};
    man_out    = sum_s[MAN_W-1:0];
    carry      = sum_s[MAN_W];
    inexact    = guard | sticky;
  end

endmodule

// File: rtl/fp_multiplier_pipe.sv
// Three-stage pipelined floating-point multiplier with RNE rounding, flush-to-zero,
// special-value handling and a valid/ready handshake. All stages advance together.
module fp_multiplier_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [FLAG_W-1:0]        flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EW   = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;

  localparam logic signed [EW-1:0] BIAS_S    = EW'(BIAS);
  localparam logic signed [EW-1:0] ONE_S     = EW'(32'sd1);
  localparam logic signed [EW-1:0] ZERO_S    = {EW{1'b0}};
  localparam logic signed [EW-1:0] EXP_MAX_S = EW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0]     EXP_ONES  = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0]     EXP_NONE  = {EXP_W{1'b0}};
  localparam logic [MAN_W-1:0]     FRAC_NONE = {MAN_W{1'b0}};

  logic adv_s;

  // Stage 1 combinational unpack
  logic [EXP_W-1:0]     ea_s, eb_s;
  logic [MAN_W-1:0]     fa_s, fb_s;
  fp_class_e            cls_a_s, cls_b_s;
  logic                 snan_s, inf_zero_s;
  fp_special_e          special_s;
  logic                 inv_s;
  logic signed [EW-1:0] exp_sum_s;
  logic [PW-1:0]        prod_s;

  // Stage 1 registers
  logic                 v1_r, sign1_r, inv1_r;
  fp_special_e          special1_r;
  logic signed [EW-1:0] exp1_r;
  logic [PW-1:0]        prod1_r;

  // Stage 2 combinational normalise/round
  logic [MAN_W-1:0]     man_pre_s, man_rnd_s;
  logic                 guard_s, sticky_s, rnd_carry_s, rnd_inx_s;
  logic signed [EW-1:0] exp_norm_s, exp_rnd_s;

  // Stage 2 registers
  logic                 v2_r, sign2_r, inv2_r, inx2_r;
  fp_special_e          special2_r;
  logic signed [EW-1:0] exp2_r;
  logic [MAN_W-1:0]     man2_r;

  // Stage 3 combinational range check and pack
  logic [W-1:0]         res_s;
  logic [FLAG_W-1:0]    flags_s;

  assign adv_s    = ~out_valid | out_ready;
  assign in_ready = adv_s;

  // Unpack operands, classify, and pick any special-value override
  always_comb begin
    ea_s       = a[W-2 -: EXP_W];
    eb_s       = b[W-2 -: EXP_W];
    fa_s       = a[MAN_W-1:0];
    fb_s       = b[MAN_W-1:0];
    cls_a_s    = classify(ea_s == EXP_ONES, ea_s == EXP_NONE, fa_s == FRAC_NONE);
    cls_b_s    = classify(eb_s == EXP_ONES, eb_s == EXP_NONE, fb_s == FRAC_NONE);
    snan_s     = ((cls_a_s == NAN) & ~fa_s[MAN_W-1]) | ((cls_b_s == NAN) & ~fb_s[MAN_W-1]);
    inf_zero_s = ((cls_a_s == INF) & (cls_b_s == ZERO)) | ((cls_a_s == ZERO) & (cls_b_s == INF));
    exp_sum_s  = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - BIAS_S;
    prod_s     = {{(MAN_W+1){1'b0}}, 1'b1, fa_s} * {{(MAN_W+1){1'b0}}, 1'b1, fb_s};
    special_s  = SP_NONE;
    inv_s      = 1'b0;
    if ((cls_a_s == NAN) || (cls_b_s == NAN) || inf_zero_s) begin
      special_s = SP_QNAN;
      inv_s     = snan_s | inf_zero_s;
    end else if ((cls_a_s == INF) || (cls_b_s == INF)) begin
      special_s = SP_INF;
    end else if ((cls_a_s == ZERO) || (cls_b_s == ZERO)) begin
      special_s = SP_ZERO;
    end else begin
      special_s = SP_NONE;
    end
  end

  // Select the normalised fraction, guard and sticky from the raw product
  always_comb begin
    if (prod1_r[PW-1]) begin
      man_pre_s  = prod1_r[PW-2 -: MAN_W];
      guard_s    = prod1_r[MAN_W];
      sticky_s   = |prod1_r[MAN_W-1:0];
      exp_norm_s = exp1_r + ONE_S;
    end else begin
      man_pre_s  = prod1_r[PW-3 -: MAN_W];
      guard_s    = prod1_r[MAN_W-1];
      sticky_s   = |prod1_r[MAN_W-2:0];
      exp_norm_s = exp1_r;
    end
  end

  fp_round_rne #(.MAN_W(MAN_W)) u_round (
    .man_in  (man_pre_s),
    .guard   (guard_s),
    .sticky  (sticky_s),
    .man_out (man_rnd_s),
    .carry   (rnd_carry_s),
    .inexact (rnd_inx_s)
  );

  // A rounding carry renormalises 10.000 to 1.000 with the exponent bumped
  always_comb begin
    if (rnd_carry_s) begin
      exp_rnd_s = exp_norm_s + ONE_S;
    end else begin
      exp_rnd_s = exp_norm_s;
    end
  end

  // Apply overrides, then overflow/underflow range checks, and pack the word
  always_comb begin
    res_s   = {W{1'b0}};
    flags_s = {FLAG_W{1'b0}};
    case (special2_r)
      SP_QNAN: begin
        res_s            = W'(pack_qnan(EXP_W, MAN_W));
        flags_s[FLAG_INV] = inv2_r;
      end
      SP_INF: begin
        res_s = W'(pack_inf(EXP_W, MAN_W, sign2_r));
      end
      SP_ZERO: begin
        res_s = W'(pack_zero(EXP_W, MAN_W, sign2_r));
      end
      SP_NONE: begin
        if (exp2_r >= EXP_MAX_S) begin
          res_s             = W'(pack_inf(EXP_W, MAN_W, sign2_r));
          flags_s[FLAG_OVF] = 1'b1;
          flags_s[FLAG_INX] = 1'b1;
        end else if (exp2_r <= ZERO_S) begin
          res_s             = W'(pack_zero(EXP_W, MAN_W, sign2_r));
          flags_s[FLAG_UNF] = 1'b1;
          flags_s[FLAG_INX] = 1'b1;
        end else begin
          res_s             = {sign2_r, exp2_r[EXP_W-1:0], man2_r};
          flags_s[FLAG_INX] = inx2_r;
        end
      end
      default: begin
        res_s   = {W{1'b0}};
        flags_s = {FLAG_W{1'b0}};
      end
    endcase
  end

  // Valid bits of all three stages shift together whenever the pipe advances
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv_s) begin
      v1_r      <= in_valid;
      v2_r      <= v1_r;
      out_valid <= v2_r;
    end
  end

  // Stage 1 payload: captured only on an accepted operand pair
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign1_r    <= 1'b0;
      inv1_r     <= 1'b0;
      special1_r <= SP_NONE;
      exp1_r     <= ZERO_S;
      prod1_r    <= {PW{1'b0}};
    end else if (adv_s && in_valid) begin
      sign1_r    <= a[W-1] ^ b[W-1];
      inv1_r     <= inv_s;
      special1_r <= special_s;
      exp1_r     <= exp_sum_s;
      prod1_r    <= prod_s;
    end
  end

  // Stage 2 payload: rounded fraction and adjusted exponent
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign2_r    <= 1'b0;
      inv2_r     <= 1'b0;
      inx2_r     <= 1'b0;
      special2_r <= SP_NONE;
      exp2_r     <= ZERO_S;
      man2_r     <= {MAN_W{1'b0}};
    end else if (adv_s && v1_r) begin
      sign2_r    <= sign1_r;
      inv2_r     <= inv1_r;
      inx2_r     <= rnd_inx_s;
      special2_r <= special1_r;
      exp2_r     <= exp_rnd_s;
      man2_r     <= man_rnd_s;
    end
  end

  // Output registers: held while the consumer stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= {W{1'b0}};
      flags  <= {FLAG_W{1'b0}};
    end else if (adv_s && v2_r) begin
      result <= res_s;
      flags  <= flags_s;
    end
  end

endmodule

// File: tb/tb_fp_multiplier_pipe.sv
// Directed bench for fp_multiplier_pipe: single-precision vector table, a stalled
// back-to-back burst, reset with operations in flight, and a half-precision instance.
module tb_fp_multiplier_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] ha, hb, hresult;
  logic [3:0]  hflags;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  fp_multiplier_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  fp_multiplier_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(ha), .b(hb), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .result(hresult), .flags(hflags)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{32'hBF400000, 32'hBF400000, 32'h3F100000, 4'b0000};
    vecs[1]  = '{32'h3F000000, 32'h3EE00000, 32'h3E600000, 4'b0000};
    vecs[2]  = '{32'hBF000000, 32'h3EE00000, 32'hBE600000, 4'b0000};
    vecs[3]  = '{32'h3F000000, 32'hBEE00000, 32'hBE600000, 4'b0000};
    vecs[4]  = '{32'hBF000000, 32'hBEE00000, 32'h3E600000, 4'b0000};
    vecs[5]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001};
    vecs[6]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101};
    vecs[7]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000};
    vecs[8]  = '{32'h3FC00000, 32'h3F800001, 32'h3FC00002, 4'b0001};
    vecs[9]  = '{32'h3FC00000, 32'h3F800003, 32'h3FC00004, 4'b0001};
    vecs[10] = '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0011};
    vecs[11] = '{32'h80800000, 32'h00800000, 32'h80000000, 4'b0011};
    vecs[12] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000};
    vecs[13] = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000};
    vecs[14] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};
    vecs[15] = '{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000};
    vecs[16] = '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000};
    vecs[17] = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000};
    vecs[18] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101};
    vecs[19] = '{32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000};
    vecs[20] = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011};
    vecs[21] = '{32'hFF800000, 32'h00000000, 32'h7FC00000, 4'b1000};
    vecs[22] = '{32'h7F800000, 32'hFF800000, 32'hFF800000, 4'b0000};
    vecs[23] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001};

    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = 32'h0; b = 32'h0;
    h_in_valid = 1'b0; h_out_ready = 1'b1; ha = 16'h0; hb = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", {31'h0, out_valid}, 32'h0);
    check("reset result", result, 32'h0);
    check("reset flags", {28'h0, flags}, 32'h0);
    reset = 1'b0;
    #1;
    check("in_ready after release", {31'h0, in_ready}, 32'h1);

    // Table: one operation at a time, latency measured in rising edges incl. the accept edge
    for (int i = 0; i < NV; i++) begin
      int lat;
      in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b; out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check($sformatf("vec%0d latency", i), lat, 32'd3);
      check($sformatf("vec%0d result", i), result, vecs[i].res);
      check($sformatf("vec%0d flags", i), {28'h0, flags}, {28'h0, vecs[i].fl});
    end
    @(posedge clk);
    #1;

    // Burst of 10 back-to-back operations with the consumer stalled in cycles 4-8
    begin : burst
      int sent = 0;
      int got = 0;
      int cyc = 0;
      logic held_v = 1'b0;
      logic saw_stall = 1'b0;
      logic [31:0] held_res = 32'h0;
      logic [3:0] held_fl = 4'h0;
      while (got < 10 && cyc < 60) begin
        cyc++;
        in_valid  = (sent < 10);
        a         = vecs[sent].a;
        b         = vecs[sent].b;
        out_ready = !(cyc >= 4 && cyc <= 8);
        #1;
        if (held_v) begin
          check("burst hold valid", {31'h0, out_valid}, 32'h1);
          check("burst hold result", result, held_res);
          check("burst hold flags", {28'h0, flags}, {28'h0, held_fl});
        end
        if (out_valid && !out_ready) begin
          saw_stall = 1'b1;
          check("burst in_ready during stall", {31'h0, in_ready}, 32'h0);
        end
        if (out_valid && out_ready) begin
          check($sformatf("burst out%0d result", got), result, vecs[got].res);
          check($sformatf("burst out%0d flags", got), {28'h0, flags}, {28'h0, vecs[got].fl});
          got++;
        end
        held_v   = out_valid & ~out_ready;
        held_res = result;
        held_fl  = flags;
        if (in_valid && in_ready) sent++;
        @(posedge clk);
        #1;
      end
      check("burst received count", got, 32'd10);
      check("burst sent count", sent, 32'd10);
      check("burst stall seen", {31'h0, saw_stall}, 32'h1);
      check("burst done within 20 cycles", {31'h0, cyc <= 20}, 32'h1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset with two operations in flight
    in_valid = 1'b1; a = vecs[0].a; b = vecs[0].b;
    @(posedge clk);
    #1;
    a = vecs[1].a; b = vecs[1].b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("inflight reset out_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("inflight reset out_valid edge", {31'h0, out_valid}, 32'h0);
    check("inflight reset result", result, 32'h0);
    check("inflight reset flags", {28'h0, flags}, {28'h0, 4'h0});
    reset = 1'b0;
    #1;
    check("inflight in_ready after release", {31'h0, in_ready}, 32'h1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("no stale output c%0d", i), {31'h0, out_valid}, 32'h0);
    end

    // Half-precision instance: 1.0*2.0, rounding, overflow
    for (int i = 0; i < 3; i++) begin
      logic [15:0] xa, xb, xr;
      logic [3:0]  xf;
      int lat;
      case (i)
        0:       begin xa = 16'h3C00; xb = 16'h4000; xr = 16'h4000; xf = 4'b0000; end
        1:       begin xa = 16'h3C01; xb = 16'h3C01; xr = 16'h3C02; xf = 4'b0001; end
        default: begin xa = 16'h7BFF; xb = 16'h7BFF; xr = 16'h7C00; xf = 4'b0101; end
      endcase
      h_in_valid = 1'b1; ha = xa; hb = xb;
      @(posedge clk);
      #1;
      h_in_valid = 1'b0;
      lat = 1;
      while (!h_out_valid && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check($sformatf("half%0d latency", i), lat, 32'd3);
      check($sformatf("half%0d result", i), {16'h0, hresult}, {16'h0, xr});
      check($sformatf("half%0d flags", i), {28'h0, hflags}, {28'h0, xf});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
